card_dealer: RTL and testbench



---
 rtl/card_dealer.sv | 164 ++++++++++++++++
 tb/tb_card_dealer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Card source for the 18-point game: draws LFSR cards into four slots, settles, and latches the round verdict.
// Optional build macro CARD_DEALER_AUTO_STAND_EN: auto-stand on a full four-card hand that is still under 18.
module card_dealer #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned MAX_CARD   = 10,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic [1:0] judge_state,
  output logic [3:0] first_card,
  output logic [3:0] second_card,
  output logic [3:0] third_card,
  output logic [3:0] fourth_card,
  output logic [2:0] card_count,
  output logic       busy,
  output logic       round_over,
  output logic [1:0] result
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAL1,
    ST_DEAL2,
    ST_SETTLE,
    ST_PLAYER,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE  = 2'b00,
    RES_STOOD = 2'b01,
    RES_EXACT = 2'b10,
    RES_BUST  = 2'b11
  } result_e;

  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam logic [3:0]  CARD_MAX    = 4'(MAX_CARD);
  localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE_CYC - 1);
  localparam logic [1:0]  JUDGE_UNDER = 2'b01;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [3:0][3:0] slot_q, slot_d;
  logic [2:0]      count_q, count_d;
  logic [2:0]      settle_q, settle_d;
  result_e         result_q, result_d;

  logic [3:0] card_raw;
  logic [3:0] card_value;
  logic       verdict;
  logic       slot_free;
  logic       auto_stand;

  // Free-running Galois LFSR, right shift; it never pauses so card draws depend on timing.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

  // Fold the low nibble into 1..MAX_CARD; the value is taken from the pre-edge LFSR content.
  assign card_raw   = lfsr_q[3:0];
  assign card_value = (card_raw >= CARD_MAX) ? (card_raw - CARD_MAX + 4'd1)
                                             : (card_raw + 4'd1);

  assign verdict   = judge_state[1];
  assign slot_free = (count_q < 3'd4);

`ifdef CARD_DEALER_AUTO_STAND_EN
  assign auto_stand = (count_q == 3'd4) && (judge_state == JUDGE_UNDER);
`else
  assign auto_stand = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no branch leaves one unassigned and infers a latch.
    state_d  = state_q;
    slot_d   = slot_q;
    count_d  = count_q;
    settle_d = settle_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_DEAL1;
          result_d = RES_NONE;
        end
      end
      ST_DEAL1: begin
        slot_d[0] = card_value;
        count_d   = 3'd1;
        state_d   = ST_DEAL2;
      end
      ST_DEAL2: begin
        slot_d[1] = card_value;
        count_d   = 3'd2;
        settle_d  = 3'd0;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_PLAYER;
        end else begin
          settle_d = settle_q + 3'd1;
        end
      end
      ST_PLAYER: begin
        if (verdict) begin
          state_d  = ST_DONE;
          result_d = result_e'(judge_state);
        end else if (stand || auto_stand) begin
          state_d  = ST_DONE;
          result_d = RES_STOOD;
        end else if (hit && slot_free) begin
          slot_d[count_q[1:0]] = card_value;
          count_d              = count_q + 3'd1;
          settle_d             = 3'd0;
          state_d              = ST_SETTLE;
        end
        // Emptying the hand on DONE entry lets the classifier fall back to idle right after its verdict.
        if (state_d == ST_DONE) begin
          slot_d  = '0;
          count_d = 3'd0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED;
      slot_q   <= '0;
      count_q  <= 3'd0;
      settle_q <= 3'd0;
      result_q <= RES_NONE;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      slot_q   <= slot_d;
      count_q  <= count_d;
      settle_q <= settle_d;
      result_q <= result_d;
    end
  end

  assign first_card  = slot_q[0];
  assign second_card = slot_q[1];
  assign third_card  = slot_q[2];
  assign fourth_card = slot_q[3];
  assign card_count  = count_q;
  assign busy        = (state_q != ST_IDLE);
  assign round_over  = (state_q == ST_DONE);
  assign result      = result_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: scenario tasks plus random rounds against a hand-level reference model.
// The model follows CARD_DEALER_AUTO_STAND_EN the same way the design does.
module tb_card_dealer;

  localparam logic [15:0] SEED       = 16'hACE1;
  localparam int          MAX_CARD   = 10;
  localparam int          SETTLE_CYC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic [1:0] judge_state = 2'b00;
  logic [3:0] first_card, second_card, third_card, fourth_card;
  logic [2:0] card_count;
  logic       busy, round_over;
  logic [1:0] result;

  int         n_checks = 0;
  int         n_fail = 0;
  int         edges = 0;
  int         exp_card[4] = '{0, 0, 0, 0};
  int         exp_count = 0;
  logic [1:0] exp_result = 2'b00;

  card_dealer #(
    .SEED      (SEED),
    .MAX_CARD  (MAX_CARD),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hit        (hit),
    .stand      (stand),
    .judge_state(judge_state),
    .first_card (first_card),
    .second_card(second_card),
    .third_card (third_card),
    .fourth_card(fourth_card),
    .card_count (card_count),
    .busy       (busy),
    .round_over (round_over),
    .result     (result)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release: the LFSR has stepped exactly this many times.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  // Card drawn from the LFSR after k steps from SEED.
  function automatic int card_at(int k);
    logic [15:0] v;
    int n;
    v = SEED;
    repeat (k) v = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    n = int'(v[3:0]);
    return ((n >= MAX_CARD) ? n - MAX_CARD : n) + 1;
  endfunction

  function automatic int hand_sum();
    return exp_card[0] + exp_card[1] + exp_card[2] + exp_card[3];
  endfunction

  // Classifier behaviour seen at PLAYER time: idle on an empty hand, otherwise compare against 18.
  function automatic logic [1:0] classify(int sum);
    if (sum == 0) return 2'b00;
    if (sum < 18) return 2'b01;
    if (sum == 18) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [23:0] observed();
    return {first_card, second_card, third_card, fourth_card, card_count, busy, round_over, result};
  endfunction

  function automatic logic [23:0] exp_vec(logic b, logic ro);
    return {4'(exp_card[0]), 4'(exp_card[1]), 4'(exp_card[2]), 4'(exp_card[3]),
            3'(exp_count), b, ro, exp_result};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_hand();
    for (int i = 0; i < 4; i++) exp_card[i] = 0;
    exp_count = 0;
  endtask

  // Starts a round from IDLE and returns on the negedge right after PLAYER is entered.
  task automatic deal_opening();
    start = 1'b1;
    step();
    start = 1'b0;
    clear_hand();
    exp_result = 2'b00;
    n_checks++;
    if (observed() !== exp_vec(1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL deal_accept: got %h want %h", observed(), exp_vec(1'b1, 1'b0));
    end
    step();
    exp_card[0] = card_at(edges - 1);
    exp_count   = 1;
    judge_state = classify(hand_sum());
    n_checks++;
    if (observed() !== exp_vec(1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL deal_first: got %h want %h", observed(), exp_vec(1'b1, 1'b0));
    end
    n_checks++;
    if (!(int'(first_card) inside {[1:MAX_CARD]})) begin
      n_fail++;
      $display("FAIL first_range: got %0d want 1..%0d", first_card, MAX_CARD);
    end
    step();
    exp_card[1] = card_at(edges - 1);
    exp_count   = 2;
    judge_state = classify(hand_sum());
    n_checks++;
    if (observed() !== exp_vec(1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL deal_second: got %h want %h", observed(), exp_vec(1'b1, 1'b0));
    end
    n_checks++;
    if (!(int'(second_card) inside {[1:MAX_CARD]})) begin
      n_fail++;
      $display("FAIL second_range: got %0d want 1..%0d", second_card, MAX_CARD);
    end
    repeat (SETTLE_CYC) step();
    n_checks++;
    if (observed() !== exp_vec(1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL settle: got %h want %h", observed(), exp_vec(1'b1, 1'b0));
    end
  endtask

  // One PLAYER decision; the model resolves priority from the rules and predicts the outcome.
  task automatic player_action(input bit do_hit, input bit do_stand, input logic [1:0] js,
                               input string name, output bit in_round);
    bit         done;
    logic [1:0] r;
    hit         = do_hit;
    stand       = do_stand;
    judge_state = js;
    done        = 1'b0;
    r           = 2'b00;
    if (js == 2'b10 || js == 2'b11) begin
      done = 1'b1;
      r    = js;
    end else if (do_stand) begin
      done = 1'b1;
      r    = 2'b01;
    end
`ifdef CARD_DEALER_AUTO_STAND_EN
    else if (exp_count == 4 && js == 2'b01) begin
      done = 1'b1;
      r    = 2'b01;
    end
`endif
    step();
    hit   = 1'b0;
    stand = 1'b0;
    if (done) begin
      clear_hand();
      exp_result  = r;
      judge_state = 2'b00;
      n_checks++;
      if (observed() !== exp_vec(1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL %s_done: got %h want %h", name, observed(), exp_vec(1'b1, 1'b1));
      end
      step();
      n_checks++;
      if (observed() !== exp_vec(1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL %s_idle: got %h want %h", name, observed(), exp_vec(1'b0, 1'b0));
      end
      in_round = 1'b0;
    end else if (do_hit && exp_count < 4) begin
      exp_card[exp_count] = card_at(edges - 1);
      exp_count++;
      n_checks++;
      if (observed() !== exp_vec(1'b1, 1'b0)) begin
        n_fail++;
        $display("FAIL %s_hit: got %h want %h", name, observed(), exp_vec(1'b1, 1'b0));
      end
      repeat (SETTLE_CYC) step();
      in_round = 1'b1;
    end else begin
      n_checks++;
      if (observed() !== exp_vec(1'b1, 1'b0)) begin
        n_fail++;
        $display("FAIL %s_hold: got %h want %h", name, observed(), exp_vec(1'b1, 1'b0));
      end
      in_round = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit in_round;
    repeat (2) step();
    n_checks++;
    if (observed() !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_por: got %h want %h", observed(), 24'h0);
    end
    rst = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_checks++;
    if (int'(first_card) !== card_at(edges - 1)) begin
      n_fail++;
      $display("FAIL reset_pre_card: got %0d want %0d", first_card, card_at(edges - 1));
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (observed() !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want %h", observed(), 24'h0);
    end
    step();
    step();
    rst = 1'b1;
    clear_hand();
    exp_result = 2'b00;
    deal_opening();
    player_action(1'b0, 1'b1, 2'b01, "reset_end", in_round);
  endtask

  task automatic test_deal();
    bit in_round;
    stand = 1'b1;
    deal_opening();
    player_action(1'b0, 1'b1, 2'b01, "deal_stand", in_round);
  endtask

  task automatic test_hit_cap();
    bit in_round;
    deal_opening();
    in_round = 1'b1;
    for (int i = 0; i < 4 && in_round; i++) player_action(1'b1, 1'b0, 2'b01, "hit_cap", in_round);
    if (in_round) begin
      n_checks++;
      if (card_count !== 3'd4) begin
        n_fail++;
        $display("FAIL hit_cap_count: got %0d want 4", card_count);
      end
      player_action(1'b0, 1'b1, 2'b01, "hit_cap_stand", in_round);
    end
  endtask

  task automatic test_exact18();
    bit in_round;
    deal_opening();
    player_action(1'b0, 1'b0, 2'b10, "exact18", in_round);
    repeat (20) begin
      hit   = 1'($urandom_range(0, 1));
      stand = 1'($urandom_range(0, 1));
      step();
    end
    hit   = 1'b0;
    stand = 1'b0;
    n_checks++;
    if (observed() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL exact18_hold: got %h want %h", observed(), exp_vec(1'b0, 1'b0));
    end
    deal_opening();
    player_action(1'b0, 1'b1, 2'b01, "exact18_end", in_round);
  endtask

  task automatic test_priority();
    bit in_round;
    deal_opening();
    player_action(1'b1, 1'b1, 2'b11, "prio_bust", in_round);
    deal_opening();
    player_action(1'b1, 1'b1, 2'b01, "prio_stand", in_round);
    deal_opening();
    player_action(1'b1, 1'b0, 2'b10, "prio_exact", in_round);
  endtask

  task automatic test_auto_stand();
    bit in_round;
    deal_opening();
    player_action(1'b1, 1'b0, 2'b01, "auto_fill", in_round);
    player_action(1'b1, 1'b0, 2'b01, "auto_fill", in_round);
`ifdef CARD_DEALER_AUTO_STAND_EN
    player_action(1'b0, 1'b0, 2'b01, "auto_stand", in_round);
`else
    judge_state = 2'b01;
    repeat (100) step();
    n_checks++;
    if (observed() !== exp_vec(1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL no_auto_stand: got %h want %h", observed(), exp_vec(1'b1, 1'b0));
    end
    player_action(1'b0, 1'b1, 2'b01, "auto_end", in_round);
`endif
  endtask

  task automatic test_random_rounds();
    bit in_round;
    int sel;
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 3)) begin
        hit   = 1'($urandom_range(0, 1));
        stand = 1'($urandom_range(0, 1));
        step();
      end
      hit   = 1'b0;
      stand = 1'b0;
      n_checks++;
      if (observed() !== exp_vec(1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL idle_gap: got %h want %h", observed(), exp_vec(1'b0, 1'b0));
      end
      deal_opening();
      in_round = 1'b1;
      for (int a = 0; a < 12 && in_round; a++) begin
        sel = $urandom_range(0, 9);
        player_action(sel < 6 || sel == 9, sel >= 8, classify(hand_sum()), "random", in_round);
      end
      if (in_round) player_action(1'b0, 1'b1, classify(hand_sum()), "random_end", in_round);
    end
  endtask

  initial begin
    test_reset();
    test_deal();
    test_hit_cap();
    test_exact18();
    test_priority();
    test_auto_stand();
    test_random_rounds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
